// File: rtl/frame_buffer_writer_pkg.sv
// Shared definitions for the ping-pong frame store: FSM encoding and address sizing.
// The VGA reader imports the same package for bank/address layout.
package frame_buffer_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_CAPTURE = 3'b010,
      ST_PENDING = 3'b100
   } fb_state_e;

   // Linear pixel-address width for one bank; the bank bit sits above it.
   function automatic int fb_addr_w(input int h_width, input int v_width);
      return $clog2(h_width * v_width);
   endfunction

endpackage

// File: rtl/frame_buffer_writer_addr_gen.sv
// Combinational pixel bounds check and linear address (y*H_WIDTH + x) for one commit.
module fb_addr_gen
   import frame_buffer_writer_pkg::*;
#(
   parameter int H_WIDTH     = 320,
   parameter int V_WIDTH     = 240,
   parameter int BYTE_PAIRED = 1,
   parameter int HA          = $clog2(2 * H_WIDTH),
   parameter int VA          = $clog2(V_WIDTH),
   parameter int AW          = fb_addr_w(H_WIDTH, V_WIDTH)
) (
   input  logic [HA-1:0] i_h_addr,
   input  logic [VA-1:0] i_v_addr,
   output logic          o_in_range,
   output logic [AW-1:0] o_lin_addr
);

   logic [HA-1:0] x;

   always_comb begin
      x = (BYTE_PAIRED != 0) ? (i_h_addr >> 1) : i_h_addr;
      // One extra bit on each side so a power-of-two limit does not truncate to zero.
      o_in_range = ({1'b0, x} < (HA+1)'(H_WIDTH)) &&
                   ({1'b0, i_v_addr} < (VA+1)'(V_WIDTH));
      o_lin_addr = AW'(i_v_addr) * AW'(H_WIDTH) + AW'(x);
   end

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes receiver pixels into a ping-pong BRAM frame store; swaps banks only at a
// reader frame boundary and hands the receiver its start-capture/next-frame pulses.
module frame_buffer_writer
   import frame_buffer_writer_pkg::*;
#(
   parameter int H_WIDTH     = 320,
   parameter int V_WIDTH     = 240,
   parameter int PXL_WIDTH   = 16,
   parameter int BYTE_PAIRED = 1,
   localparam int HA = $clog2(2 * H_WIDTH),
   localparam int VA = $clog2(V_WIDTH),
   localparam int AW = fb_addr_w(H_WIDTH, V_WIDTH)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [PXL_WIDTH-1:0] i_pixel_data,
   input  logic [HA-1:0]        i_h_addr,
   input  logic [VA-1:0]        i_v_addr,
   input  logic                 i_valid,
   input  logic                 i_frame_end,
   input  logic                 i_rd_frame_start,
   output logic                 o_start_capture,
   output logic                 o_next_frame,
   output logic                 o_wr_en,
   output logic [AW:0]          o_wr_addr,
   output logic [PXL_WIDTH-1:0] o_wr_data,
   output logic                 o_display_bank,
   output logic [15:0]          o_drop_count
);

   fb_state_e              state_q, state_d;
   logic                   phase_q, phase_d;
   logic [VA-1:0]          v_prev_q, v_prev_d;
   logic                   wr_bank_q, wr_bank_d;
   logic                   disp_bank_q, disp_bank_d;
   logic                   start_q, start_d;
   logic                   next_q, next_d;
   logic                   wr_en_q, wr_en_d;
   logic [AW:0]            wr_addr_q, wr_addr_d;
   logic [PXL_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [15:0]            drop_q, drop_d;

   logic                   line_phase;
   logic                   commit;
   logic                   in_range;
   logic [AW-1:0]          lin_addr;

   fb_addr_gen #(
      .H_WIDTH     (H_WIDTH),
      .V_WIDTH     (V_WIDTH),
      .BYTE_PAIRED (BYTE_PAIRED),
      .HA          (HA),
      .VA          (VA),
      .AW          (AW)
   ) u_addr_gen (
      .i_h_addr   (i_h_addr),
      .i_v_addr   (i_v_addr),
      .o_in_range (in_range),
      .o_lin_addr (lin_addr)
   );

   always_comb begin
      state_d     = state_q;
      v_prev_d    = i_v_addr;
      wr_bank_d   = wr_bank_q;
      disp_bank_d = disp_bank_q;
      start_d     = 1'b0;
      next_d      = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      drop_d      = drop_q;
      commit      = 1'b0;

      // A line change resyncs byte pairing even if the receiver dropped a byte.
      line_phase = (i_v_addr != v_prev_q) ? 1'b0 : phase_q;
      phase_d    = line_phase;

      case (state_q)
         ST_IDLE: begin
            if (i_enable) begin
               state_d = ST_CAPTURE;
               start_d = 1'b1;
               phase_d = 1'b0;
            end
         end
         ST_CAPTURE: begin
            if (i_valid) begin
               phase_d = ~line_phase;
               commit  = (BYTE_PAIRED == 0) || line_phase;
            end
            if (i_frame_end) state_d = ST_PENDING;
         end
         ST_PENDING: begin
            if (i_rd_frame_start) begin
               disp_bank_d = wr_bank_q;
               wr_bank_d   = ~wr_bank_q;
               if (i_enable) begin
                  state_d = ST_CAPTURE;
                  next_d  = 1'b1;
                  phase_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (commit) begin
         if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, lin_addr};
            wr_data_d = i_pixel_data;
         end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         phase_q     <= 1'b0;
         v_prev_q    <= '0;
         wr_bank_q   <= 1'b0;
         disp_bank_q <= 1'b1;
         start_q     <= 1'b0;
         next_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         drop_q      <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         v_prev_q    <= v_prev_d;
         wr_bank_q   <= wr_bank_d;
         disp_bank_q <= disp_bank_d;
         start_q     <= start_d;
         next_q      <= next_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         drop_q      <= drop_d;
      end
   end

   assign o_start_capture = start_q;
   assign o_next_frame    = next_q;
   assign o_wr_en         = wr_en_q;
   assign o_wr_addr       = wr_addr_q;
   assign o_wr_data       = wr_data_q;
   assign o_display_bank  = disp_bank_q;
   assign o_drop_count    = drop_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomised + directed bench for frame_buffer_writer against a behavioural frame-store model.
module tb_frame_buffer_writer;

   localparam int H  = 320;
   localparam int V  = 240;
   localparam int PW = 16;
   localparam int HA = $clog2(2 * H);
   localparam int VA = $clog2(V);
   localparam int AW = $clog2(H * V);

   logic          clk = 1'b0;
   logic          i_reset = 1'b1, i_enable = 1'b0, i_valid = 1'b0;
   logic          i_frame_end = 1'b0, i_rd_frame_start = 1'b0;
   logic [PW-1:0] i_pixel_data = '0;
   logic [HA-1:0] i_h_addr = '0;
   logic [VA-1:0] i_v_addr = '0;
   logic          o_start_capture, o_next_frame, o_wr_en, o_display_bank;
   logic [AW:0]   o_wr_addr;
   logic [PW-1:0] o_wr_data;
   logic [15:0]   o_drop_count;

   always #5 clk = ~clk;

   frame_buffer_writer #(.H_WIDTH(H), .V_WIDTH(V), .PXL_WIDTH(PW), .BYTE_PAIRED(1)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_pixel_data(i_pixel_data),
      .i_h_addr(i_h_addr), .i_v_addr(i_v_addr), .i_valid(i_valid), .i_frame_end(i_frame_end),
      .i_rd_frame_start(i_rd_frame_start), .o_start_capture(o_start_capture),
      .o_next_frame(o_next_frame), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_display_bank(o_display_bank), .o_drop_count(o_drop_count));

   int n_chk = 0, n_fail = 0;

   // Model: mode 0=idle 1=capturing 2=waiting for reader; bytes = bytes seen in current pixel.
   int   m_mode, m_wbank, m_dbank, m_bytes, m_prev_v, m_drop;
   logic e_wr, e_start, e_next;
   int   e_addr, e_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      int x, y;
      if (i_reset) begin
         m_mode = 0; m_wbank = 0; m_dbank = 1; m_bytes = 0; m_prev_v = 0; m_drop = 0;
         e_wr = 0; e_start = 0; e_next = 0; e_addr = 0; e_data = 0;
         return;
      end
      e_wr = 0; e_start = 0; e_next = 0;
      y = int'(i_v_addr);
      if (y != m_prev_v) m_bytes = 0;
      m_prev_v = y;
      if (m_mode == 1 && i_valid) begin
         m_bytes++;
         if (m_bytes == 2) begin
            m_bytes = 0;
            x = int'(i_h_addr) / 2;
            if (x < H && y < V) begin
               e_wr = 1;
               e_addr = m_wbank * (1 << AW) + y * H + x;
               e_data = int'(i_pixel_data);
            end else if (m_drop < 65535) begin
               m_drop++;
            end
         end
      end
      case (m_mode)
         0: if (i_enable) begin m_mode = 1; e_start = 1; m_bytes = 0; end
         1: if (i_frame_end) m_mode = 2;
         default: if (i_rd_frame_start) begin
            m_dbank = m_wbank;
            m_wbank = 1 - m_wbank;
            if (i_enable) begin m_mode = 1; e_next = 1; m_bytes = 0; end
            else m_mode = 0;
         end
      endcase
   endfunction

   task automatic check_all();
      chk("wr_en", 32'(o_wr_en), 32'(e_wr));
      chk("start_capture", 32'(o_start_capture), 32'(e_start));
      chk("next_frame", 32'(o_next_frame), 32'(e_next));
      chk("display_bank", 32'(o_display_bank), 32'(m_dbank));
      chk("drop_count", 32'(o_drop_count), 32'(m_drop));
      if (e_wr) begin
         chk("wr_addr", 32'(o_wr_addr), e_addr);
         chk("wr_data", 32'(o_wr_data), e_data);
      end
   endtask

   // Called at a negedge: apply inputs, advance model, check outputs at the next negedge.
   task automatic tick(input logic rst, input logic en, input logic vld, input logic fe,
                       input logic rd, input int h, input int v, input int data);
      i_reset = rst; i_enable = en; i_valid = vld; i_frame_end = fe; i_rd_frame_start = rd;
      i_h_addr = HA'(h); i_v_addr = VA'(v); i_pixel_data = PW'(data);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(0, i_enable, 0, 0, 0, 0, int'(i_v_addr), 0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) tick(1, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_wr_en", 32'(o_wr_en), 0);
      chk("rst_display_bank", 32'(o_display_bank), 1);
      chk("rst_drop", 32'(o_drop_count), 0);
      chk("rst_wr_addr", 32'(o_wr_addr), 0);
      chk("rst_wr_data", 32'(o_wr_data), 0);

      tick(0, 1, 0, 0, 0, 0, 0, 0);
      chk("start_pulse", 32'(o_start_capture), 1);
      tick(0, 1, 0, 0, 0, 0, 0, 0);
      chk("start_once", 32'(o_start_capture), 0);

      tick(0, 1, 1, 0, 0, 0, 0, 'hA0A0);
      chk("first_byte_no_wr", 32'(o_wr_en), 0);
      tick(0, 1, 1, 0, 0, 1, 0, 'hB1B1);
      chk("pix0_wr", 32'(o_wr_en), 1);
      chk("pix0_addr", 32'(o_wr_addr), 0);
      chk("pix0_data", 32'(o_wr_data), 'hB1B1);
      tick(0, 1, 1, 0, 0, 2, 0, 'hC2C2);
      tick(0, 1, 1, 0, 0, 3, 0, 'hD3D3);
      chk("pix1_addr", 32'(o_wr_addr), 1);
      chk("pix1_data", 32'(o_wr_data), 'hD3D3);

      tick(0, 1, 1, 0, 0, 640, 0, 'h1111);
      tick(0, 1, 1, 0, 0, 641, 0, 'h2222);
      chk("x_oob_no_wr", 32'(o_wr_en), 0);
      chk("x_oob_drop", 32'(o_drop_count), 1);
      tick(0, 1, 1, 0, 0, 0, 240, 'h3333);
      tick(0, 1, 1, 0, 0, 1, 240, 'h4444);
      chk("y_oob_drop", 32'(o_drop_count), 2);

      tick(0, 1, 0, 1, 0, 0, 240, 0);
      idle(10);
      tick(0, 1, 0, 0, 1, 0, 240, 0);
      chk("swap_display", 32'(o_display_bank), 0);
      chk("swap_next_frame", 32'(o_next_frame), 1);
      tick(0, 1, 1, 0, 0, 4, 0, 'h5555);
      tick(0, 1, 1, 0, 0, 5, 0, 'h6666);
      chk("swap_bank_msb", 32'(o_wr_addr[AW]), 1);
      chk("swap_addr", 32'(o_wr_addr), (1 << AW) + 2);

      tick(0, 1, 0, 1, 1, 0, 0, 0);
      idle(3);
      chk("same_cycle_no_swap", 32'(o_display_bank), 0);
      tick(0, 1, 0, 0, 1, 0, 0, 0);
      chk("late_swap", 32'(o_display_bank), 1);

      tick(0, 1, 1, 0, 0, 0, 1, 'h7777);
      tick(0, 1, 1, 0, 0, 0, 2, 'h8888);
      chk("new_line_no_wr", 32'(o_wr_en), 0);
      tick(0, 1, 1, 0, 0, 1, 2, 'h9999);
      chk("new_line_addr", 32'(o_wr_addr), 640);

      begin
         int v = 0;
         for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) v = $urandom_range(0, 250);
            tick($urandom_range(0, 799) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 700), v,
                 $urandom_range(0, 65535));
         end
      end

      tick(1, 0, 0, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0, 5, 0);
      tick(0, 1, 1, 0, 0, 10, 5, 'hAAAA);
      tick(1, 1, 1, 0, 0, 11, 5, 'hBBBB);
      chk("rst_abandon_wr", 32'(o_wr_en), 0);
      chk("rst_abandon_disp", 32'(o_display_bank), 1);
      tick(0, 1, 0, 0, 0, 0, 5, 0);
      chk("rst_restart", 32'(o_start_capture), 1);
      tick(0, 1, 1, 0, 0, 10, 5, 'hCCCC);
      tick(0, 1, 1, 0, 0, 11, 5, 'hDDDD);
      chk("rst_bank0_addr", 32'(o_wr_addr), 5 * H + 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
